cache_line_ctrl: RTL and testbench

CACHE_LINE_CTRL -- requirements
Module: cache_line_ctrl

---
 rtl/cache_ctrl_pkg.sv | 24 ++
 rtl/cache_wait_ctr.sv | 36 +++
 rtl/cache_line_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_cache_line_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/cache_ctrl_pkg.sv
// cache_ctrl_pkg -- shared definitions for the cache line controller.
//   state_e               : controller state encoding (9 legal states, 4 bits)
//   DEF_WAIT_CYCLES       : default memory wait states per access
//   DEF_WORDS_PER_LINE    : default line-fill beats per read miss
//   WAIT_CTR_W            : width of the wait-state counter (covers 1..255)
package cache_ctrl_pkg;

    localparam int unsigned DEF_WAIT_CYCLES    = 4;
    localparam int unsigned DEF_WORDS_PER_LINE = 4;
    localparam int unsigned WAIT_CTR_W         = 8;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_RD_CHK  = 4'd1,
        S_RD_MISS = 4'd2,
        S_RD_MEM  = 4'd3,
        S_RD_FILL = 4'd4,
        S_RD_DONE = 4'd5,
        S_WR_CHK  = 4'd6,
        S_WR_MEM  = 4'd7,
        S_WR_DATA = 4'd8
    } state_e;

endpackage

// File: rtl/cache_wait_ctr.sv
// cache_wait_ctr -- loadable down-counter with zero flag.
// Ports:
//   clk, reset    : clock, synchronous active-low reset (clears count)
//   load_i        : load load_val_i (has priority over dec_i)
//   load_val_i    : value to load
//   dec_i         : decrement by one; holds at zero
//   count_o       : current count
//   zero_o        : count is zero
module cache_wait_ctr #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic [WIDTH-1:0] count_o,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == '0);

endmodule

// File: rtl/cache_line_ctrl.sv
// cache_line_ctrl -- read-allocate / write-through cache line controller.
// A read miss fills the whole line one word per memory access; writes always
// go to memory and update the cache word only on a hit.
// Optional build macro: CACHE_WRITE_ALLOC_EN -- a write miss first fills the
// line, then re-runs the write as a hit.
// Ports:
//   clk, reset        : clock, synchronous active-low reset
//   Strobe, DRW       : CPU request valid, 1 = write
//   M, V              : tag match, line valid
//   DReady            : CPU transfer complete
//   W, WSel           : cache word write enable, 1 = data from memory
//   MStrobe, MRW      : memory access start, 1 = memory write
//   RSel              : 1 = CPU read data taken from memory
//   WordIdx           : fill-beat word index (0 outside RD_FILL)
//   Busy              : high in every state except IDLE
// Handshake: Strobe is sampled only in IDLE; the request is complete in the
// single cycle DReady is high, after which the controller is back in IDLE.
module cache_line_ctrl
    import cache_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES    = DEF_WAIT_CYCLES,
    parameter int unsigned WORDS_PER_LINE = DEF_WORDS_PER_LINE,
    parameter int unsigned IDX_W          = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Strobe,
    input  logic             DRW,
    input  logic             M,
    input  logic             V,
    output logic             DReady,
    output logic             W,
    output logic             MStrobe,
    output logic             MRW,
    output logic             RSel,
    output logic             WSel,
    output logic [IDX_W-1:0] WordIdx,
    output logic             Busy
);

    localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(WORDS_PER_LINE - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] beat_q, beat_d;
    logic             drw_q, drw_d;
    logic             hit_q, hit_d;
    logic             alloc_q, alloc_d;

    logic                  wait_load, wait_dec, wait_zero, wait_last;
    logic [WAIT_CTR_W-1:0] wait_cnt;

    cache_wait_ctr #(.WIDTH(WAIT_CTR_W)) u_wait_ctr (
        .clk        (clk),
        .reset      (reset),
        .load_i     (wait_load),
        .load_val_i (WAIT_CTR_W'(WAIT_CYCLES)),
        .dec_i      (wait_dec),
        .count_o    (wait_cnt),
        .zero_o     (wait_zero)
    );

    // Counter holds WAIT_CYCLES on the first wait cycle, so the final wait
    // cycle is the one where it reads 1. The zero term only guards against
    // a stuck wait if the counter were ever found empty.
    assign wait_last = (wait_cnt == WAIT_CTR_W'(1)) || wait_zero;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            drw_q   <= 1'b0;
            hit_q   <= 1'b0;
            alloc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            drw_q   <= drw_d;
            hit_q   <= hit_d;
            alloc_q <= alloc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        drw_d     = drw_q;
        hit_d     = hit_q;
        alloc_d   = alloc_q;
        wait_load = 1'b0;
        wait_dec  = 1'b0;
        DReady    = 1'b0;
        W         = 1'b0;
        MStrobe   = 1'b0;
        MRW       = 1'b0;
        RSel      = 1'b0;
        WSel      = 1'b0;
        WordIdx   = '0;
        Busy      = 1'b1;

        case (state_q)
            S_IDLE: begin
                Busy = 1'b0;
                if (Strobe) begin
                    drw_d   = DRW;
                    state_d = DRW ? S_WR_CHK : S_RD_CHK;
                end
            end
            S_RD_CHK: begin
                if (M && V) begin
                    DReady  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    beat_d  = '0;
                    state_d = S_RD_MISS;
                end
            end
            S_RD_MISS: begin
                MStrobe   = 1'b1;
                wait_load = 1'b1;
                state_d   = S_RD_MEM;
            end
            S_RD_MEM: begin
                wait_dec = 1'b1;
                if (wait_last) state_d = S_RD_FILL;
            end
            S_RD_FILL: begin
                W       = 1'b1;
                WSel    = 1'b1;
                WordIdx = beat_q;
                if (beat_q == LAST_BEAT) begin
                    // An allocating write re-enters the write path once the line is present.
                    state_d = (alloc_q && drw_q) ? S_WR_CHK : S_RD_DONE;
                end else begin
                    beat_d  = beat_q + IDX_W'(1);
                    state_d = S_RD_MISS;
                end
            end
            S_RD_DONE: begin
                DReady  = 1'b1;
                RSel    = 1'b1;
                state_d = S_IDLE;
            end
            S_WR_CHK: begin
`ifdef CACHE_WRITE_ALLOC_EN
                if (!(M && V) && !alloc_q) begin
                    alloc_d = 1'b1;
                    beat_d  = '0;
                    state_d = S_RD_MISS;
                end else begin
                    hit_d     = 1'b1;
                    MStrobe   = 1'b1;
                    MRW       = 1'b1;
                    wait_load = 1'b1;
                    state_d   = S_WR_MEM;
                end
`else
                hit_d     = M && V;
                MStrobe   = 1'b1;
                MRW       = 1'b1;
                wait_load = 1'b1;
                state_d   = S_WR_MEM;
`endif
            end
            S_WR_MEM: begin
                MRW      = 1'b1;
                wait_dec = 1'b1;
                if (wait_last) state_d = S_WR_DATA;
            end
            S_WR_DATA: begin
                DReady  = 1'b1;
                MRW     = 1'b1;
                W       = hit_q;
                hit_d   = 1'b0;
                alloc_d = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                Busy    = 1'b0;
                state_d = S_IDLE;
            end
        endcase

        // Outputs are held quiet for the whole reset cycle, not just after it.
        if (!reset) begin
            DReady  = 1'b0;
            W       = 1'b0;
            MStrobe = 1'b0;
            MRW     = 1'b0;
            RSel    = 1'b0;
            WSel    = 1'b0;
            WordIdx = '0;
            Busy    = 1'b0;
        end
    end

endmodule

// File: tb/tb_cache_line_ctrl.sv
module tb_cache_line_ctrl;

    localparam int WAIT  = 4;
    localparam int WPL   = 4;
    localparam int IDX_W = 2;
    localparam int TIMEOUT = 100;

    logic             clk = 1'b0;
    logic             reset;
    logic             Strobe, DRW, M, V;
    logic             DReady, W, MStrobe, MRW, RSel, WSel, Busy;
    logic [IDX_W-1:0] WordIdx;
    logic [8:0]       out_vec;

    assign out_vec = {DReady, W, MStrobe, MRW, RSel, WSel, Busy, WordIdx};

    cache_line_ctrl #(.WAIT_CYCLES(WAIT), .WORDS_PER_LINE(WPL), .IDX_W(IDX_W)) dut (
        .clk     (clk),
        .reset   (reset),
        .Strobe  (Strobe),
        .DRW     (DRW),
        .M       (M),
        .V       (V),
        .DReady  (DReady),
        .W       (W),
        .MStrobe (MStrobe),
        .MRW     (MRW),
        .RSel    (RSel),
        .WSel    (WSel),
        .WordIdx (WordIdx),
        .Busy    (Busy)
    );

    // clock / reset
    always #5 clk = ~clk;

    // scoreboard
    int n_cmp  = 0;
    int n_fail = 0;
    int exp_q[$];
    int ms_cyc_q[$];
    int w_cyc_q[$];
    int w_idx_q[$];

    function automatic void check(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // Compare a recorded queue against exp_q, entry by entry.
    function automatic void check_q(string name, int got_q[$]);
        check({name, " count"}, got_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k < got_q.size()) check($sformatf("%s[%0d]", name, k), got_q[k], exp_q[k]);
        end
        exp_q.delete();
    endfunction

    typedef struct {
        logic drw, m, v;
        int   dr;       // DReady cycle after the Strobe cycle
        int   ms;       // MStrobe pulses
        int   wc;       // W pulses
        logic w_dr, rsel_dr, mrw_dr, mrw_ms;
    } vec_t;

    vec_t vecs[6];

    // driver: one CPU transaction, cycle 0 is the IDLE cycle with Strobe=1
    task automatic run_txn(input logic drw, input logic m, input logic v, input bit toggle,
                           output int dr_cyc, output int ms_cnt, output int w_cnt,
                           output logic w_dr, output logic rsel_dr, output logic mrw_dr,
                           output logic mrw_ms, output logic busy_ok, output logic idx_ok);
        dr_cyc = -1; ms_cnt = 0; w_cnt = 0;
        w_dr = 0; rsel_dr = 0; mrw_dr = 0; mrw_ms = 0; busy_ok = 1; idx_ok = 1;
        ms_cyc_q.delete(); w_cyc_q.delete(); w_idx_q.delete();
        DRW = drw; M = m; V = v; Strobe = 1'b1;
        for (int cyc = 1; cyc <= TIMEOUT; cyc++) begin
            @(posedge clk); #1;
            if (!Busy) busy_ok = 0;
            if (!W && WordIdx != '0) idx_ok = 0;
            if (MStrobe) begin
                ms_cnt++; ms_cyc_q.push_back(cyc); mrw_ms = MRW;
            end
            if (W) begin
                w_cnt++; w_cyc_q.push_back(cyc); w_idx_q.push_back(int'(WordIdx));
            end
            if (DReady) begin
                dr_cyc = cyc; w_dr = W; rsel_dr = RSel; mrw_dr = MRW;
                break;
            end
            Strobe = toggle ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        Strobe = 1'b0;
    endtask

    task automatic run_vec(input int i, input bit toggle);
        int dr, ms, wc;
        logic wdr, rsdr, mrdr, mrms, bok, iok;
        string p;
        p = $sformatf("%s v%0d", toggle ? "tog" : "tbl", i);
        run_txn(vecs[i].drw, vecs[i].m, vecs[i].v, toggle, dr, ms, wc, wdr, rsdr, mrdr, mrms, bok, iok);
        check({p, " dready_cyc"}, dr, vecs[i].dr);
        check({p, " mstrobe_cnt"}, ms, vecs[i].ms);
        check({p, " w_cnt"}, wc, vecs[i].wc);
        check({p, " w_at_dready"}, int'(wdr), int'(vecs[i].w_dr));
        check({p, " rsel_at_dready"}, int'(rsdr), int'(vecs[i].rsel_dr));
        check({p, " mrw_at_dready"}, int'(mrdr), int'(vecs[i].mrw_dr));
        check({p, " mrw_last_mstrobe"}, int'(mrms), int'(vecs[i].mrw_ms));
        check({p, " busy_held"}, int'(bok), 1);
        check({p, " wordidx_quiet"}, int'(iok), 1);
        @(posedge clk); #1;
        check({p, " idle_after"}, int'(out_vec), 0);
    endtask

    initial begin
        int dr, ms, wc, w_seen;
        logic wdr, rsdr, mrdr, mrms, bok, iok;

        //                drw   m     v     dr  ms wc w_dr  rsel  mrw_dr mrw_ms
        vecs[0] = '{1'b0, 1'b1, 1'b1, 1,  0, 0, 1'b0, 1'b0, 1'b0, 1'b0};  // read hit
        vecs[1] = '{1'b0, 1'b0, 1'b1, 26, 4, 4, 1'b0, 1'b1, 1'b0, 1'b0};  // read miss, tag
        vecs[2] = '{1'b0, 1'b1, 1'b0, 26, 4, 4, 1'b0, 1'b1, 1'b0, 1'b0};  // read miss, invalid
        vecs[3] = '{1'b1, 1'b1, 1'b1, 6,  1, 1, 1'b1, 1'b0, 1'b1, 1'b1};  // write hit
`ifdef CACHE_WRITE_ALLOC_EN
        vecs[4] = '{1'b1, 1'b0, 1'b1, 31, 5, 5, 1'b1, 1'b0, 1'b1, 1'b1};  // write miss, allocate
        vecs[5] = '{1'b1, 1'b0, 1'b0, 31, 5, 5, 1'b1, 1'b0, 1'b1, 1'b1};
`else
        vecs[4] = '{1'b1, 1'b0, 1'b1, 6,  1, 0, 1'b0, 1'b0, 1'b1, 1'b1};  // write miss, no allocate
        vecs[5] = '{1'b1, 1'b0, 1'b0, 6,  1, 0, 1'b0, 1'b0, 1'b1, 1'b1};
`endif

        reset = 1'b0; Strobe = 1'b0; DRW = 1'b0; M = 1'b0; V = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset outputs", int'(out_vec), 0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("idle after reset", int'(out_vec), 0);

        // table-driven vectors
        for (int i = 0; i < 6; i++) run_vec(i, 1'b0);

        // read miss: beat timing and word indices
        run_txn(1'b0, 1'b0, 1'b1, 1'b0, dr, ms, wc, wdr, rsdr, mrdr, mrms, bok, iok);
        check("rdmiss dready_cyc", dr, 2 + WPL * (WAIT + 2));
        for (int k = 0; k < WPL; k++) exp_q.push_back(2 + k * (WAIT + 2));
        check_q("rdmiss mstrobe_cyc", ms_cyc_q);
        for (int k = 0; k < WPL; k++) exp_q.push_back(7 + k * (WAIT + 2));
        check_q("rdmiss w_cyc", w_cyc_q);
        for (int k = 0; k < WPL; k++) exp_q.push_back(k);
        check_q("rdmiss w_idx", w_idx_q);
        @(posedge clk); #1;

        // write hit: MStrobe at 1, W/DReady at 6
        run_txn(1'b1, 1'b1, 1'b1, 1'b0, dr, ms, wc, wdr, rsdr, mrdr, mrms, bok, iok);
        exp_q.push_back(1);
        check_q("wrhit mstrobe_cyc", ms_cyc_q);
        exp_q.push_back(WAIT + 2);
        check_q("wrhit w_cyc", w_cyc_q);
        @(posedge clk); #1;

        // Strobe toggling while busy must not disturb anything
        run_vec(1, 1'b1);
        run_vec(3, 1'b1);
        run_vec(4, 1'b1);

        // reset during RD_MEM of beat 2 (cycles 15..18)
        DRW = 1'b0; M = 1'b0; V = 1'b1; Strobe = 1'b1;
        w_seen = 0;
        for (int cyc = 1; cyc <= 16; cyc++) begin
            @(posedge clk); #1;
            Strobe = 1'b0;
            if (W) w_seen++;
        end
        check("midfill beats before reset", w_seen, 2);
        check("midfill busy before reset", int'(Busy), 1);
        reset = 1'b0;
        #1;
        check("midfill outputs during reset", int'(out_vec), 0);
        @(posedge clk); #1;
        check("midfill outputs after reset edge", int'(out_vec), 0);
        reset = 1'b1;
        w_seen = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(posedge clk); #1;
            if (out_vec != '0) w_seen++;
        end
        check("midfill no activity after reset", w_seen, 0);
        run_vec(0, 1'b0);
        run_vec(1, 1'b0);

        // reset during the write wait states
        DRW = 1'b1; M = 1'b1; V = 1'b1; Strobe = 1'b1;
        @(posedge clk); #1;
        Strobe = 1'b0;
        @(posedge clk); #1;
        check("midwrite mrw before reset", int'(MRW), 1);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        w_seen = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(posedge clk); #1;
            if (out_vec != '0) w_seen++;
        end
        check("midwrite no activity after reset", w_seen, 0);
        run_vec(3, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
